// File: rtl/bitmap_pkg.sv
// Shared definitions for the 1-bpp bitmap writer: FSM encoding, coordinate width, row byte count.
package bitmap_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    COMMIT = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // Bytes per row; every row starts on a fresh byte.
  function automatic int bpr(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/bitmap_ram.sv
// Row-wide simple dual-port bitmap store: one synchronous row write, registered single-pixel read.
// Out-of-range reads return 0; a same-cycle read of the row being written returns the old contents.
module bitmap_ram
  import bitmap_pkg::*;
#(
  parameter int width  = 100,
  parameter int height = 92
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [COORD_W-1:0] wa,
  input  logic [width-1:0]   wd,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  output logic               pixel
);

  localparam int AW = (height > 1) ? $clog2(height) : 1;
  localparam int XW = (width > 1) ? $clog2(width) : 1;
  localparam logic [COORD_W-1:0] W_L = COORD_W'(width);
  localparam logic [COORD_W-1:0] H_L = COORD_W'(height);

  logic [width-1:0] mem [height];
  logic [width-1:0] rd_row;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we && (wa < H_L)) mem[wa[AW-1:0]] <= wd;
  end

  assign rd_row = mem[ry[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pixel <= 1'b0;
    else if ((rx < W_L) && (ry < H_L)) pixel <= rd_row[rx[XW-1:0]];
    else pixel <= 1'b0;
  end

endmodule

// File: rtl/bitmap_writer.sv
// Packs a valid/ready byte stream row-major into a width x height 1-bpp bitmap with a registered read port.
// Optional BITMAP_WRITER_CLEAR_EN adds a clear input that zeroes memory one row per cycle.
module bitmap_writer
  import bitmap_pkg::*;
#(
  parameter int width  = 100,
  parameter int height = 92
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               restart,
`ifdef BITMAP_WRITER_CLEAR_EN
  input  logic               clear,
`endif
  input  logic [COORD_W-1:0] x_img,
  input  logic [COORD_W-1:0] y_img,
  output logic               pixel,
  output logic               frame_done
);

  localparam int BPR = bpr(width);
  localparam int SW  = BPR * 8;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(BPR - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(height - 1);

  state_t             state, state_nxt;
  logic [COORD_W-1:0] col, col_nxt;
  logic [COORD_W-1:0] wr_row, wr_row_nxt;
  logic [SW-1:0]      sbuf;
  logic [width-1:0]   row_pix;
  logic [width-1:0]   wd;
  logic               we;
  logic               accept;
  logic               done_nxt;

  assign in_ready = (state == RECV);

  // Bytes shift in from the bottom, so after a full row byte 0 bit 7 sits at the MSB.
  always_comb begin
    row_pix = '0;
    for (int x = 0; x < width; x++) row_pix[x] = sbuf[SW-1-x];
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    wr_row_nxt = wr_row;
    done_nxt   = 1'b0;
    we         = 1'b0;
    wd         = row_pix;
    accept     = 1'b0;
    case (state)
      RECV: begin
        if (restart) begin
          col_nxt    = '0;
          wr_row_nxt = '0;
        end else if (in_valid) begin
          accept = 1'b1;
          if (col == LAST_COL) begin
            col_nxt   = '0;
            state_nxt = COMMIT;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      COMMIT: begin
        we        = 1'b1;
        state_nxt = RECV;
        if (restart) begin
          col_nxt    = '0;
          wr_row_nxt = '0;
        end else if (wr_row == LAST_ROW) begin
          wr_row_nxt = '0;
          done_nxt   = 1'b1;
        end else begin
          wr_row_nxt = wr_row + 1'b1;
        end
      end
`ifdef BITMAP_WRITER_CLEAR_EN
      CLEAR: begin
        we = 1'b1;
        wd = '0;
        if (wr_row == LAST_ROW) begin
          wr_row_nxt = '0;
          col_nxt    = '0;
          state_nxt  = RECV;
          done_nxt   = 1'b1;
        end else begin
          wr_row_nxt = wr_row + 1'b1;
        end
      end
`endif
      default: state_nxt = RECV;
    endcase
`ifdef BITMAP_WRITER_CLEAR_EN
    // Clear overrides everything, including a pending commit and restart.
    if (clear) begin
      state_nxt  = CLEAR;
      wr_row_nxt = '0;
      col_nxt    = '0;
      we         = 1'b0;
      accept     = 1'b0;
      done_nxt   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RECV;
      col        <= '0;
      wr_row     <= '0;
      sbuf       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      wr_row     <= wr_row_nxt;
      frame_done <= done_nxt;
      if (accept) sbuf <= (sbuf << 8) | SW'(in_data);
    end
  end

  bitmap_ram #(.width(width), .height(height)) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .wa    (wr_row),
    .wd    (wd),
    .rx    (x_img),
    .ry    (y_img),
    .pixel (pixel)
  );

endmodule

// File: tb/tb_bitmap_writer.sv
// Directed bench for bitmap_writer (100 x 92); the clear section builds only with BITMAP_WRITER_CLEAR_EN.
module tb_bitmap_writer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       restart = 1'b0;
  logic [9:0] x_img = 10'd0;
  logic [9:0] y_img = 10'd0;
  logic       pixel;
  logic       frame_done;
`ifdef BITMAP_WRITER_CLEAR_EN
  logic       clear = 1'b0;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int fd_cnt  = 0;
  int low_cnt = 0;

  logic [7:0]  cur [13];
  logic [99:0] model [92];

  bitmap_writer #(.width(100), .height(92)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .restart    (restart),
`ifdef BITMAP_WRITER_CLEAR_EN
    .clear      (clear),
`endif
    .x_img      (x_img),
    .y_img      (y_img),
    .pixel      (pixel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (rstn && !in_ready) low_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 128'(0), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_row(input int r, input bit gaps);
    logic [99:0] row;
    int idle;
    row = '0;
    for (int k = 0; k < 13; k++) begin
      if (gaps) begin
        idle = 0;
        while ($urandom_range(0, 9) >= 3 && idle < 20) begin
          @(negedge clk);
          idle++;
        end
      end
      send(cur[k]);
      for (int i = 0; i < 8; i++)
        if (8 * k + i < 100) row[8*k+i] = cur[k][7-i];
    end
    model[r] = row;
  endtask

  task automatic read_px(input int x, input int y, output logic v);
    x_img = 10'(x);
    y_img = 10'(y);
    @(negedge clk);
    v = pixel;
  endtask

  task automatic read_row(input int y, output logic [99:0] row);
    logic v;
    for (int x = 0; x < 100; x++) begin
      read_px(x, y, v);
      row[x] = v;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    logic        v;
    logic [99:0] rd;
    int          fd0;

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_pixel", 128'(pixel), 128'(0));
    chk("reset_frame_done", 128'(frame_done), 128'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Full frame of 0xFF with continuous valid.
    low_cnt = 0;
    fd_cnt  = 0;
    for (int k = 0; k < 13; k++) cur[k] = 8'hFF;
    for (int r = 0; r < 92; r++) begin
      send_row(r, 1'b0);
      if (r == 0 || r == 45 || r == 91) chk("commit_gap", 128'(in_ready), 128'(0));
    end
    repeat (3) @(negedge clk);
    chk("frame_done_once", 128'(fd_cnt), 128'(1));
    chk("ready_low_cycles", 128'(low_cnt), 128'(92));
    read_px(99, 91, v);   chk("px_99_91", 128'(v), 128'(1));
    read_px(100, 0, v);   chk("px_100_0", 128'(v), 128'(0));
    read_px(0, 92, v);    chk("px_0_92", 128'(v), 128'(0));
    read_px(1023, 1023, v); chk("px_far", 128'(v), 128'(0));

    // Row 0 bit order and pad-bit discard.
    pulse_restart();
    cur[0] = 8'h80;
    for (int k = 1; k < 12; k++) cur[k] = 8'h00;
    cur[12] = 8'h0F;
    send_row(0, 1'b0);
    @(negedge clk);
    read_px(0, 0, v);  chk("px_0_0", 128'(v), 128'(1));
    read_px(1, 0, v);  chk("px_1_0", 128'(v), 128'(0));
    read_px(7, 0, v);  chk("px_7_0", 128'(v), 128'(0));
    read_row(0, rd);
    chk("row0_pad", 128'(rd), 128'(100'h1));

    // Random data, sparse valid.
    pulse_restart();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 13; k++) cur[k] = 8'($urandom);
      send_row(r, 1'b1);
    end
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      read_row(r, rd);
      chk($sformatf("rand_row%0d", r), 128'(rd), 128'(model[r]));
    end

    // Restart mid-row 3.
    fd0 = fd_cnt;
    pulse_restart();
    for (int k = 0; k < 13; k++) cur[k] = 8'h00;
    for (int r = 0; r < 3; r++) send_row(r, 1'b0);
    for (int k = 0; k < 5; k++) send(8'h55);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    pulse_restart();
    in_valid = 1'b0;
    cur[0] = 8'h80;
    send_row(0, 1'b0);
    @(negedge clk);
    read_row(3, rd);   chk("row3_kept", 128'(rd), 128'(model[3]));
    read_px(0, 0, v);  chk("restart_px_0_0", 128'(v), 128'(1));
    read_px(8, 0, v);  chk("restart_px_8_0", 128'(v), 128'(0));
    chk("restart_no_done", 128'(fd_cnt), 128'(fd0));

    // Read of row 0 in the same cycle as its commit.
    pulse_restart();
    for (int k = 0; k < 13; k++) cur[k] = 8'h00;
    send_row(0, 1'b0);
    pulse_restart();
    for (int k = 0; k < 13; k++) cur[k] = 8'hFF;
    for (int k = 0; k < 13; k++) send(cur[k]);
    chk("collide_in_commit", 128'(in_ready), 128'(0));
    x_img = 10'd5;
    y_img = 10'd0;
    @(negedge clk);
    chk("collide_old", 128'(pixel), 128'(0));
    @(negedge clk);
    chk("collide_new", 128'(pixel), 128'(1));

`ifdef BITMAP_WRITER_CLEAR_EN
    begin
      int n;
      logic any;
      pulse_restart();
      for (int r = 0; r < 92; r++) send_row(r, 1'b0);
      repeat (3) @(negedge clk);
      read_px(50, 50, v); chk("preclear_px", 128'(v), 128'(1));
      fd0 = fd_cnt;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("clear_low_cycles", 128'(n), 128'(92));
      repeat (2) @(negedge clk);
      chk("clear_done", 128'(fd_cnt), 128'(fd0 + 1));
      any = 1'b0;
      for (int y = 0; y < 92; y++) begin
        read_row(y, rd);
        any = any | (|rd);
      end
      chk("clear_all_zero", 128'(any), 128'(0));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
